// File: rtl/fp32_rsqrt_arbiter_pkg.sv
// fp32_rsqrt_arbiter_pkg: shared types, limits and helpers for the rsqrt arbiter slice
package fp32_rsqrt_arbiter_pkg;
  typedef logic [31:0] fp32_t;
  localparam int RSQRT_ARB_MAX_REQ = 8;
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction
endpackage

// File: rtl/rsqrt_tag_fifo.sv
// rsqrt_tag_fifo: synchronous FIFO holding requester tags of in-flight rsqrt operations
module rsqrt_tag_fifo
  import fp32_rsqrt_arbiter_pkg::*;
#(
  parameter int W = 2,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [CW-1:0] o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("rsqrt_tag_fifo: DEPTH must be a power of two");
  end
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      if (i_push && !i_pop) r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end
  assign o_dout = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/fp32_rsqrt_arbiter.sv
// fp32_rsqrt_arbiter: round-robin sharing of one pipelined fp32 rsqrt unit,
// with in-order tag tracking so each result returns to the requester that issued it
module fp32_rsqrt_arbiter
  import fp32_rsqrt_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int TAG_DEPTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req_vld,
  output logic [NUM_REQ-1:0] o_req_rdy,
  input  fp32_t              i_req_a [NUM_REQ],
  output logic               o_rsu_op_vld,
  output fp32_t              o_rsu_a,
  input  logic               i_rsu_result_vld,
  input  fp32_t              i_rsu_result,
  output logic [NUM_REQ-1:0] o_rsp_vld,
  output fp32_t              o_rsp_data,
  output logic               o_busy,
  output logic               o_err_spurious
);
  localparam int CW = $clog2(TAG_DEPTH + 1);
  if (NUM_REQ < 2 || NUM_REQ > RSQRT_ARB_MAX_REQ) begin : g_bad_num_req
    $error("fp32_rsqrt_arbiter: NUM_REQ out of range");
  end
  if (!is_pow2(TAG_DEPTH)) begin : g_bad_tag_depth
    $error("fp32_rsqrt_arbiter: TAG_DEPTH must be a power of two");
  end
  logic [ID_W-1:0] r_rr_ptr, w_idx, w_gnt_id, w_rr_nxt, w_head;
  logic [CW-1:0] w_count;
  logic w_found, w_full, w_empty, w_pop;
  logic r_rsu_op_vld, r_err_spurious;
  fp32_t r_rsu_a, r_rsp_data;
  logic [NUM_REQ-1:0] r_rsp_vld;
  assign w_full = (w_count == CW'(TAG_DEPTH));
  assign w_empty = (w_count == '0);
  assign w_pop = i_rsu_result_vld && !w_empty;
  // first eligible requester at or after the round-robin pointer wins
  always_comb begin
    w_found = 1'b0;
    w_gnt_id = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && !w_full && i_req_vld[w_idx]) begin
        w_found = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end
  assign w_rr_nxt = ID_W'((int'(w_gnt_id) + 1) % NUM_REQ);
  assign o_req_rdy = w_found ? (NUM_REQ'(1) << w_gnt_id) : '0;
  rsqrt_tag_fifo #(.W(ID_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_push(w_found),
    .i_din(w_gnt_id),
    .i_pop(w_pop),
    .o_dout(w_head),
    .o_count(w_count)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsu_op_vld <= 1'b0;
      r_rsu_a <= '0;
      r_rr_ptr <= '0;
      r_rsp_vld <= '0;
      r_rsp_data <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      r_rsu_op_vld <= w_found;
      if (w_found) begin
        r_rsu_a <= i_req_a[w_gnt_id];
        r_rr_ptr <= w_rr_nxt;
      end
      r_rsp_vld <= w_pop ? (NUM_REQ'(1) << w_head) : '0;
      if (w_pop) r_rsp_data <= i_rsu_result;
      // a result with no outstanding tag cannot be routed; flag it until reset
      if (i_rsu_result_vld && w_empty) r_err_spurious <= 1'b1;
    end
  end
  assign o_rsu_op_vld = r_rsu_op_vld;
  assign o_rsu_a = r_rsu_a;
  assign o_rsp_vld = r_rsp_vld;
  assign o_rsp_data = r_rsp_data;
  assign o_busy = !w_empty;
  assign o_err_spurious = r_err_spurious;
endmodule

// File: tb/tb_fp32_rsqrt_arbiter.sv
// tb_fp32_rsqrt_arbiter: randomized self-checking bench with a latency-5 unit model on the
// main instance and hand-driven results on a TAG_DEPTH=4 instance
module tb_fp32_rsqrt_arbiter;
  import fp32_rsqrt_arbiter_pkg::*;
  localparam int N = 4;
  localparam int LAT = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req_vld;
  fp32_t req_a [N];
  logic [N-1:0] rdy, rsp_vld, rdy_s, rsp_vld_s;
  logic op_vld, res_vld, busy, err, op_vld_s, res_vld_s, busy_s, err_s;
  fp32_t rsu_a, res, rsp_data, rsu_a_s, res_s, rsp_data_s;
  int n_pass = 0;
  int n_total = 0;
  int q_id[$];
  fp32_t q_d[$];
  int q_s[$];
  int m_rr = 0;
  int m_rr_s = 0;
  bit have_pend = 0;
  int pend_id = 0;
  fp32_t pend_d = '0;

  fp32_rsqrt_arbiter #(.NUM_REQ(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(rdy), .i_req_a(req_a),
    .o_rsu_op_vld(op_vld), .o_rsu_a(rsu_a), .i_rsu_result_vld(res_vld), .i_rsu_result(res),
    .o_rsp_vld(rsp_vld), .o_rsp_data(rsp_data), .o_busy(busy), .o_err_spurious(err)
  );
  fp32_rsqrt_arbiter #(.NUM_REQ(N), .TAG_DEPTH(4)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(rdy_s), .i_req_a(req_a),
    .o_rsu_op_vld(op_vld_s), .o_rsu_a(rsu_a_s), .i_rsu_result_vld(res_vld_s), .i_rsu_result(res_s),
    .o_rsp_vld(rsp_vld_s), .o_rsp_data(rsp_data_s), .o_busy(busy_s), .o_err_spurious(err_s)
  );

  function automatic fp32_t rsqrt_ref(input fp32_t a);
    real x, y;
    logic [63:0] b;
    x = (1.0 + real'(a[22:0]) / 8388608.0) * (2.0 ** real'(int'(a[30:23]) - 127));
    y = 1.0 / $sqrt(x);
    b = $realtobits(y);
    return {b[63], 8'(int'(b[62:52]) - 896), b[51:29]};
  endfunction

  function automatic int winner(input int rr, input logic [N-1:0] v, input bit room);
    if (!room) return -1;
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic fp32_t rand_op();
    return {1'b0, 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
  endfunction

  // behavioural rsqrt unit: fixed latency, flushed together with the arbiter
  logic [LAT-1:0] pv;
  fp32_t pd [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= '0;
    else begin
      pv <= {pv[LAT-2:0], op_vld};
      pd[0] <= rsqrt_ref(rsu_a);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign res_vld = pv[LAT-1];
  assign res = pd[LAT-1];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_vld = '0;
    res_vld_s = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0;
    m_rr_s = 0;
    have_pend = 0;
    q_id.delete();
    q_d.delete();
    q_s.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_vld = '0;
    #1;
    n_total++;
    if ({op_vld, rsu_a, rsp_vld, rsp_data, busy, err} !== '0)
      $display("FAIL reset_main: got op=%b a=%h rsp=%b d=%h busy=%b err=%b want all 0", op_vld, rsu_a, rsp_vld, rsp_data, busy, err);
    else n_pass++;
    n_total++;
    if ({op_vld_s, rsu_a_s, rsp_vld_s, rsp_data_s, busy_s, err_s, rdy} !== '0)
      $display("FAIL reset_small: got op=%b busy=%b err=%b rdy=%b want all 0", op_vld_s, busy_s, err_s, rdy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_vld = 4'b1000;
    #1;
    n_total++;
    if (rdy !== 4'b1000) $display("FAIL reset_rdy_follows: got %b want 1000", rdy);
    else n_pass++;
    req_vld = '0;
  endtask

  task automatic test_single();
    int hit;
    logic [N-1:0] got;
    fp32_t gotd, oa;
    logic ov, ob;
    do_reset();
    @(negedge clk);
    req_a[2] = 32'h40800000;
    req_vld = 4'b0100;
    #1;
    n_total++;
    if (rdy !== 4'b0100) $display("FAIL single_rdy: got %b want 0100", rdy);
    else n_pass++;
    hit = -1; got = '0; gotd = '0; ov = 1'b0; ob = 1'b0; oa = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin ov = op_vld; oa = rsu_a; ob = busy; req_vld = '0; end
      if (rsp_vld !== '0 && hit < 0) begin hit = c; got = rsp_vld; gotd = rsp_data; end
    end
    n_total++;
    if (ov !== 1'b1 || oa !== 32'h40800000 || ob !== 1'b1)
      $display("FAIL single_issue: got op=%b a=%h busy=%b want 1 40800000 1", ov, oa, ob);
    else n_pass++;
    n_total++;
    if (hit !== 7) $display("FAIL single_latency: got %0d want 7", hit);
    else n_pass++;
    n_total++;
    if (got !== 4'b0100 || gotd !== 32'h3F000000)
      $display("FAIL single_rsp: got %b/%h want 0100/3f000000", got, gotd);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int e_id;
    fp32_t e_d;
    do_reset();
    for (int i = 0; i < N; i++) req_a[i] = {1'b0, 8'(110 + 5 * i), 23'($urandom)};
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      if (rsp_vld !== '0) begin
        n_total++;
        if (q_id.size() == 0) $display("FAIL rr_rsp: got %b want none", rsp_vld);
        else begin
          e_id = q_id.pop_front();
          e_d = q_d.pop_front();
          if (rsp_vld !== N'(1 << e_id) || rsp_data !== e_d)
            $display("FAIL rr_rsp: got %b/%h want %b/%h", rsp_vld, rsp_data, N'(1 << e_id), e_d);
          else n_pass++;
        end
      end
      req_vld = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        n_total++;
        if (rdy !== N'(1 << (c % N))) $display("FAIL rr_grant%0d: got %b want %b", c, rdy, N'(1 << (c % N)));
        else n_pass++;
        q_id.push_back(c % N);
        q_d.push_back(rsqrt_ref(req_a[c % N]));
        m_rr = (c + 1) % N;
      end
    end
    n_total++;
    if (q_id.size() != 0 || busy !== 1'b0) $display("FAIL rr_drain: got %0d left busy=%b want 0 0", q_id.size(), busy);
    else n_pass++;
  endtask

  task automatic test_random();
    int w, e_id;
    fp32_t e_d;
    logic [N-1:0] e;
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      if (rsp_vld !== '0) begin
        n_total++;
        if (q_id.size() == 0) $display("FAIL rand_rsp: got %b want none", rsp_vld);
        else begin
          e_id = q_id.pop_front();
          e_d = q_d.pop_front();
          if (rsp_vld !== N'(1 << e_id) || rsp_data !== e_d)
            $display("FAIL rand_rsp: got %b/%h want %b/%h", rsp_vld, rsp_data, N'(1 << e_id), e_d);
          else n_pass++;
        end
      end
      req_vld = (c < 300) ? N'($urandom) : '0;
      foreach (req_a[i]) req_a[i] = rand_op();
      #1;
      w = winner(m_rr, req_vld, q_id.size() < 32);
      e = (w < 0) ? '0 : N'(1 << w);
      n_total++;
      if (rdy !== e) $display("FAIL rand_rdy%0d: got %b want %b", c, rdy, e);
      else n_pass++;
      if (w >= 0) begin
        q_id.push_back(w);
        q_d.push_back(rsqrt_ref(req_a[w]));
        m_rr = (w + 1) % N;
      end
    end
    n_total++;
    if (q_id.size() != 0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL rand_drain: got %0d left busy=%b err=%b want 0 0 0", q_id.size(), busy, err);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int e_id;
    fp32_t e_d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_a[k] = rand_op();
      req_vld = N'(1 << k);
    end
    @(negedge clk);
    req_vld = '0;
    n_total++;
    if (busy !== 1'b1 || op_vld !== 1'b1) $display("FAIL midrst_pre: got busy=%b op=%b want 1 1", busy, op_vld);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({op_vld, rsu_a, rsp_vld, rsp_data, busy, err} !== '0)
      $display("FAIL midrst_zero: got op=%b a=%h rsp=%b busy=%b err=%b want all 0", op_vld, rsu_a, rsp_vld, busy, err);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q_id.delete();
    q_d.delete();
    m_rr = 0;
    @(negedge clk);
    req_vld = 4'hF;
    foreach (req_a[i]) req_a[i] = rand_op();
    #1;
    n_total++;
    if (rdy !== 4'b0001) $display("FAIL midrst_rr: got %b want 0001", rdy);
    else n_pass++;
    q_id.push_back(0);
    q_d.push_back(rsqrt_ref(req_a[0]));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req_vld = '0;
      if (rsp_vld !== '0) begin
        n_total++;
        if (q_id.size() == 0) $display("FAIL midrst_rsp: got %b want none", rsp_vld);
        else begin
          e_id = q_id.pop_front();
          e_d = q_d.pop_front();
          if (rsp_vld !== N'(1 << e_id) || rsp_data !== e_d)
            $display("FAIL midrst_rsp: got %b/%h want %b/%h", rsp_vld, rsp_data, N'(1 << e_id), e_d);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (q_id.size() != 0 || err !== 1'b0) $display("FAIL midrst_clean: got %0d left err=%b want 0 0", q_id.size(), err);
    else n_pass++;
  endtask

  task automatic test_spurious();
    int ngr;
    do_reset();
    @(negedge clk);
    res_vld_s = 1'b1;
    res_s = rand_op();
    @(negedge clk);
    res_vld_s = 1'b0;
    n_total++;
    if (err_s !== 1'b1 || rsp_vld_s !== '0 || busy_s !== 1'b0)
      $display("FAIL spur_flag: got err=%b rsp=%b busy=%b want 1 0000 0", err_s, rsp_vld_s, busy_s);
    else n_pass++;
    ngr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_vld = 4'b0001;
      #1;
      if (rdy_s !== '0) ngr++;
    end
    req_vld = '0;
    n_total++;
    if (ngr !== 4 || err_s !== 1'b1) $display("FAIL spur_count: got %0d grants err=%b want 4 1", ngr, err_s);
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL spur_main: got %b want 0", err);
    else n_pass++;
    do_reset();
    n_total++;
    if (err_s !== 1'b0) $display("FAIL spur_clear: got %b want 0", err_s);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] tv [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    bit tp [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int ngr, w;
    logic [N-1:0] e;
    do_reset();
    ngr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      e = have_pend ? N'(1 << pend_id) : '0;
      n_total++;
      if (rsp_vld_s !== e || (have_pend && rsp_data_s !== pend_d) || busy_s !== (q_s.size() != 0))
        $display("FAIL bp_rsp%0d: got %b/%h busy=%b want %b/%h busy=%b", c, rsp_vld_s, rsp_data_s, busy_s, e, pend_d, q_s.size() != 0);
      else n_pass++;
      req_vld = tv[c];
      res_vld_s = tp[c];
      res_s = rand_op();
      foreach (req_a[i]) req_a[i] = rand_op();
      #1;
      w = winner(m_rr_s, req_vld, q_s.size() < 4);
      e = (w < 0) ? '0 : N'(1 << w);
      n_total++;
      if (rdy_s !== e) $display("FAIL bp_rdy%0d: got %b want %b", c, rdy_s, e);
      else n_pass++;
      if (c < 6 && rdy_s !== '0) ngr++;
      have_pend = res_vld_s && q_s.size() != 0;
      if (have_pend) begin pend_id = q_s.pop_front(); pend_d = res_s; end
      if (w >= 0) begin q_s.push_back(w); m_rr_s = (w + 1) % N; end
    end
    n_total++;
    if (ngr !== 4) $display("FAIL bp_grants: got %0d want 4", ngr);
    else n_pass++;
  endtask

  task automatic test_push_pop_same();
    logic [N-1:0] tv [9] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    bit tp [9] = '{1, 1, 0, 0, 1, 1, 1, 1, 0};
    int ngr, w;
    logic [N-1:0] e;
    ngr = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      e = have_pend ? N'(1 << pend_id) : '0;
      n_total++;
      if (rsp_vld_s !== e || (have_pend && rsp_data_s !== pend_d) || busy_s !== (q_s.size() != 0))
        $display("FAIL pp_rsp%0d: got %b/%h busy=%b want %b/%h busy=%b", c, rsp_vld_s, rsp_data_s, busy_s, e, pend_d, q_s.size() != 0);
      else n_pass++;
      req_vld = tv[c];
      res_vld_s = tp[c];
      res_s = rand_op();
      foreach (req_a[i]) req_a[i] = rand_op();
      #1;
      w = winner(m_rr_s, req_vld, q_s.size() < 4);
      e = (w < 0) ? '0 : N'(1 << w);
      n_total++;
      if (rdy_s !== e) $display("FAIL pp_rdy%0d: got %b want %b", c, rdy_s, e);
      else n_pass++;
      if (c >= 1 && c <= 3 && rdy_s !== '0) ngr++;
      have_pend = res_vld_s && q_s.size() != 0;
      if (have_pend) begin pend_id = q_s.pop_front(); pend_d = res_s; end
      if (w >= 0) begin q_s.push_back(w); m_rr_s = (w + 1) % N; end
    end
    res_vld_s = 1'b0;
    req_vld = '0;
    n_total++;
    if (ngr !== 2) $display("FAIL pp_grants: got %0d want 2", ngr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy_s !== 1'b0 || rsp_vld_s !== '0 || err_s !== 1'b0)
      $display("FAIL pp_idle: got busy=%b rsp=%b err=%b want 0 0000 0", busy_s, rsp_vld_s, err_s);
    else n_pass++;
  endtask

  initial begin
    req_vld = '0;
    res_vld_s = 1'b0;
    res_s = '0;
    foreach (req_a[i]) req_a[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_mid_reset();
    test_spurious();
    test_backpressure();
    test_push_pop_same();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
